// File: rtl/serial_readout_pkg.sv
// ----------------------------------------------------------------------------
// serial_readout_pkg
// Shared definitions for the serial readout scheduler:
//   state_e    - frame sequencer states (IDLE, START, ID, DATA, GAP)
//   START_BIT  - line level driven during the start-of-packet cycle
//   GAP_LEVEL  - line level driven whenever no packet bit is on the pin
//   imax()     - integer maximum, used to size the bit counter
// ----------------------------------------------------------------------------
package serial_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ID,
        DATA,
        GAP
    } state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic GAP_LEVEL = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at the channel after
// last_i (wrapping at NUM_CH) and returns the first requesting channel.
// The pointer register lives in the parent.
//   req_i   in   NUM_CH  request vector
//   last_i  in   ID_W    most recently granted channel
//   gnt_o   out  NUM_CH  one-hot grant (all zero when no request)
//   idx_o   out  ID_W    encoded index of gnt_o (0 when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [ID_W-1:0]   last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [ID_W-1:0]   idx_o
);

    logic found;

    // NOTE: every output of a combinational block gets a default before any
    //       branch; otherwise an unassigned path infers a latch.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Offset k = 1..NUM_CH walks the ring starting just after last_i;
        // NUM_CH need not be a power of two, hence the explicit modulo.
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req_i[i] && (i == (int'(last_i) + k) % NUM_CH)) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/serial_readout_scheduler.sv
// ----------------------------------------------------------------------------
// serial_readout_scheduler
// Shares one serial pin between NUM_CH readout channels. In IDLE the
// round-robin winner is accepted, its word and ID are captured, and a packet
// is shifted out: start bit, ID (LSB first), data (LSB first), then one GAP
// cycle before the next grant.
//   CLK         in   1             clock, rising edge
//   RST_N       in   1             synchronous active-low reset
//   enable      in   1             permits new grants (running frames finish)
//   req_valid   in   NUM_CH        channel i has a word pending
//   req_data    in   NUM_CH*WIDTH  channel i word at [i*WIDTH +: WIDTH]
//   req_ready   out  NUM_CH        one-hot accept, combinational, IDLE only
//   ser_out     out  1             serial data (registered)
//   ser_frame   out  1             packet bit on ser_out (registered)
//   busy        out  1             START through GAP (registered)
//   frame_done  out  1             pulse during GAP (registered)
// ----------------------------------------------------------------------------
module serial_readout_scheduler
    import serial_readout_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]       req_ready,
    output logic                    ser_out,
    output logic                    ser_frame,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int ID_W  = $clog2(NUM_CH);
    localparam int SH_W  = ID_W + WIDTH;
    localparam int CNT_W = $clog2(imax(ID_W, WIDTH)) + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic                ser_out_q, ser_out_d;
    logic                ser_frame_q, ser_frame_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic [WIDTH-1:0]    win_data;
    logic                grant_go;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req_i  (req_valid),
        .last_i (last_grant_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // Word of the winning channel (AND-OR mux over the one-hot grant).
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by RST_N so a requester never sees an accept on an edge that the
    // reset discards.
    assign grant_go = (state_q == IDLE) && enable && (|req_valid) && RST_N;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (grant_go) begin
                    req_ready    = arb_gnt;
                    // ID sits in the low bits so it leaves the pin first.
                    sh_d         = {win_data, arb_idx};
                    last_grant_d = arb_idx;
                    cnt_d        = '0;
                    state_d      = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = ID;
            end
            ID: begin
                if (cnt_q == CNT_W'(ID_W - 1)) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so the pin
        // level lines up with state_q in the following cycle.
        ser_out_d    = GAP_LEVEL;
        ser_frame_d  = 1'b0;
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == GAP);
        case (state_d)
            START: begin
                ser_frame_d = 1'b1;
                ser_out_d   = START_BIT;
            end
            ID, DATA: begin
                ser_frame_d = 1'b1;
                ser_out_d   = sh_q[0];
                sh_d        = sh_q >> 1;
            end
            default: begin
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    //       samples the pre-edge value regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            // NOTE: the shift register is reset too; a mid-frame reset must
            //       not leave a stale word that could be mistaken for data.
            sh_q         <= '0;
            last_grant_q <= ID_W'(NUM_CH - 1);
            ser_out_q    <= 1'b0;
            ser_frame_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            last_grant_q <= last_grant_d;
            ser_out_q    <= ser_out_d;
            ser_frame_q  <= ser_frame_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_frame  = ser_frame_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
